// File: rtl/latch_bank_write_arbiter_pkg.sv
// Shared types and helpers for the latch bank write arbiter.
// Holds the sequencer state encoding and small constant functions
// used to size address, pointer and phase-counter fields.
package latch_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_VERIFY = 3'd4,
        ST_DONE   = 3'd5
    } arb_state_e;

    // Index width for n items, never narrower than one bit
    function automatic int aw_of(input int n);
        if (n <= 1) return 1;
        else return $clog2(n);
    endfunction

    // Largest of three phase lengths, sizes the shared phase counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/latch_bank_write_arbiter_if.sv
// Bundle of requester-side and latch-bank-side signals of the arbiter.
// master: requester logic plus latch bank Q outputs; slave: the arbiter.
interface latch_bank_write_arbiter_if
    import latch_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int N_CELLS = 4,
    parameter int WIDTH   = 8
);

    localparam int AW = aw_of(N_CELLS);

    logic [N_REQ-1:0]         req;
    logic [N_REQ*AW-1:0]      req_addr;
    logic [N_REQ*WIDTH-1:0]   req_data;
    logic [N_REQ-1:0]         gnt;
    logic [N_REQ-1:0]         done;
    logic                     busy;
    logic                     err;
    logic [N_CELLS-1:0]       load;
    logic [WIDTH-1:0]         data;
    logic [N_CELLS*WIDTH-1:0] bank_q;

    modport master (
        output req, req_addr, req_data, bank_q,
        input  gnt, done, busy, err, load, data
    );

    modport slave (
        input  req, req_addr, req_data, bank_q,
        output gnt, done, busy, err, load, data
    );

endinterface

// File: rtl/latch_bank_write_arbiter_rr_arbiter.sv
// Round-robin winner selection: scans requests starting at rr_ptr
// and returns a one-hot winner plus an any-request flag.
module rr_arbiter
    import latch_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int PW   = aw_of(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] win,
    output logic             any
);

    logic [PW-1:0] idx;

    // First active request at or after rr_ptr, wrapping around
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PW'((int'(rr_ptr) + i) % N_REQ);
            if (!any && req[idx]) begin
                win[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/latch_bank_write_arbiter.sv
// Write sequencer/arbiter for a shared bank of d_latch cells.
// Grants one requester at a time round-robin, then drives data with
// setup, load-pulse and hold phases so data is stable around load.
// Optional feature macro: LATCH_ARB_READBACK_EN adds a one-cycle
// VERIFY state that compares the latch Q against the written data.
module latch_bank_write_arbiter
    import latch_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int N_CELLS   = 4,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int LOAD_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input logic                       clk,
    input logic                       rst_n,
    latch_bank_write_arbiter_if.slave bus
);

    localparam int AW = aw_of(N_CELLS);
    localparam int PW = aw_of(N_REQ);
    localparam int CW = $clog2(max3(SETUP_CYC, LOAD_CYC, HOLD_CYC) + 1);

    localparam logic [CW-1:0] SETUP_LD   = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] LOAD_LD    = CW'(LOAD_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD_CYC - 1);
    localparam logic [AW:0]   CELL_LIMIT = (AW+1)'(N_CELLS);
    localparam logic [PW-1:0] LAST_REQ   = PW'(N_REQ - 1);

    arb_state_e       state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             capture;
    logic [N_REQ-1:0] win;
    logic             any;
    logic [PW-1:0]    rr_ptr, win_idx, ptr_next;
    logic [AW-1:0]    sel_addr, addr_q;
    logic [WIDTH-1:0] sel_data, data_q;
    logic [N_REQ-1:0] gnt_q;
    logic             err_q;
    logic             sel_addr_ok, addr_ok;
    logic             verify_fail;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .win    (win),
        .any    (any)
    );

    // Pick the winner's address/data and the pointer just past it
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        win_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                win_idx  = PW'(i);
                sel_addr = bus.req_addr[i*AW +: AW];
                sel_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
        ptr_next    = (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
        sel_addr_ok = ({1'b0, sel_addr} < CELL_LIMIT);
    end

    assign addr_ok = ({1'b0, addr_q} < CELL_LIMIT);

`ifdef LATCH_ARB_READBACK_EN
    logic [WIDTH-1:0] readback;

    // Select the Q output of the cell that was just written
    always_comb begin
        readback = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            if (addr_q == AW'(i)) readback = bus.bank_q[i*WIDTH +: WIDTH];
        end
    end

    assign verify_fail = (state == ST_VERIFY) && addr_ok && (readback != data_q);
`else
    logic bank_q_unused;

    assign verify_fail   = 1'b0;
    assign bank_q_unused = ^bus.bank_q;
`endif

    // State and phase counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Phase sequencing: each phase reloads the counter and counts down to zero
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any) begin
                    capture    = 1'b1;
                    state_next = ST_SETUP;
                    cnt_next   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_next = ST_LOAD;
                    cnt_next   = LOAD_LD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_LOAD: begin
                if (cnt == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
`ifdef LATCH_ARB_READBACK_EN
                    state_next = ST_VERIFY;
`else
                    state_next = ST_DONE;
`endif
                    cnt_next = '0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
`ifdef LATCH_ARB_READBACK_EN
            ST_VERIFY: state_next = ST_DONE;
`endif
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Capture the granted request, hold grant until done, keep err sticky
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            rr_ptr <= '0;
        end else begin
            if (capture) begin
                gnt_q  <= win;
                addr_q <= sel_addr;
                data_q <= sel_data;
                rr_ptr <= ptr_next;
                if (!sel_addr_ok) err_q <= 1'b1;
            end else if (state == ST_DONE) begin
                gnt_q <= '0;
            end
            if (verify_fail) err_q <= 1'b1;
        end
    end

    // One-hot load strobe, suppressed entirely for an out-of-range address
    always_comb begin
        bus.load = '0;
        if (state == ST_LOAD && addr_ok) begin
            for (int i = 0; i < N_CELLS; i++) begin
                bus.load[i] = (addr_q == AW'(i));
            end
        end
    end

    assign bus.done = (state == ST_DONE) ? gnt_q : '0;
    assign bus.busy = (state != ST_IDLE);
    assign bus.gnt  = gnt_q;
    assign bus.data = data_q;
    assign bus.err  = err_q;

endmodule
